// File: rtl/zone_stat_grid.sv
// zone_stat_grid: per-zone peak (optionally mean) gray statistics over a
// ZONES_H x ZONES_V grid of ZONE_W x ZONE_H zones inside the active window.
// Results collect in a shadow buffer and are published atomically once per
// complete frame, together with a one-cycle frame_done pulse.
// Optional feature macro: ZONE_AVG_EN (adds per-zone mean, selected by mode_avg).
module zone_stat_grid #(
  parameter int DW      = 8,
  parameter int ZONES_H = 24,
  parameter int ZONES_V = 15,
  parameter int ZONE_W  = 53,
  parameter int ZONE_H  = 53,
  parameter int X_OFF   = 4,
  parameter int Y_OFF   = 3
) (
  input  logic                          i_pix_clk,
  input  logic                          rst_n,
  input  logic                          data_de,
  input  logic [10:0]                   pix_x,
  input  logic [10:0]                   pix_y,
  input  logic [DW-1:0]                 data_gray,
  input  logic                          mode_avg,
  output logic [ZONES_H*ZONES_V*DW-1:0] zone_flat,
  output logic                          frame_done,
  output logic [7:0]                    frame_cnt
);

  localparam int NZ  = ZONES_H * ZONES_V;
  localparam int PXW = (ZONE_W  > 1) ? $clog2(ZONE_W)  : 1;
  localparam int CLW = (ZONES_H > 1) ? $clog2(ZONES_H) : 1;
  localparam int LNW = (ZONE_H  > 1) ? $clog2(ZONE_H)  : 1;
  localparam int RWW = (ZONES_V > 1) ? $clog2(ZONES_V) : 1;
  localparam int ZIW = $clog2(NZ + 1);

  localparam logic [10:0] X_LO = 11'(X_OFF);
  localparam logic [10:0] X_HI = 11'(X_OFF + ZONES_H * ZONE_W);
  localparam logic [10:0] Y_LO = 11'(Y_OFF);
  localparam logic [10:0] Y_HI = 11'(Y_OFF + ZONES_V * ZONE_H);

  localparam logic [PXW-1:0] PX_LAST = PXW'(ZONE_W - 1);
  localparam logic [CLW-1:0] CL_LAST = CLW'(ZONES_H - 1);
  localparam logic [LNW-1:0] LN_LAST = LNW'(ZONE_H - 1);
  localparam logic [RWW-1:0] RW_LAST = RWW'(ZONES_V - 1);

  // Registered counters hold the position of the next expected window pixel.
  logic [PXW-1:0] px_cnt;
  logic [CLW-1:0] col_cnt;
  logic [LNW-1:0] ln_cnt;
  logic [RWW-1:0] row_cnt;

  // Position of the pixel currently presented, after restart overrides.
  logic [PXW-1:0] cur_px,  px_nx;
  logic [CLW-1:0] cur_col, col_nx;
  logic [LNW-1:0] cur_ln,  ln_nx;
  logic [RWW-1:0] cur_row, row_nx;

  logic           in_win;
  logic           x_start;
  logic           y_start;
  logic           eol_px;
  logic           eol;
  logic           first_z;
  logic           last_z;
  logic [ZIW-1:0] zidx;
  logic [DW-1:0]  acc_sel;
  logic [DW-1:0]  peak;
  logic           pub_pend;

  logic [DW-1:0]    acc [ZONES_H];
  logic [NZ*DW-1:0] shadow_pk;
  logic [NZ*DW-1:0] pub_val;

  // Window qualification and current zone coordinates.
  always_comb begin
    in_win  = data_de && (pix_x >= X_LO) && (pix_x < X_HI) &&
              (pix_y >= Y_LO) && (pix_y < Y_HI);
    x_start = (pix_x == X_LO);
    y_start = x_start && (pix_y == Y_LO);
    cur_px  = x_start ? '0 : px_cnt;
    cur_col = x_start ? '0 : col_cnt;
    cur_ln  = y_start ? '0 : ln_cnt;
    cur_row = y_start ? '0 : row_cnt;
    eol_px  = (cur_px == PX_LAST);
    eol     = eol_px && (cur_col == CL_LAST);
    first_z = (cur_ln == '0) && (cur_px == '0);
    last_z  = (cur_ln == LN_LAST) && eol_px;
    zidx    = ZIW'(cur_row) * ZIW'(ZONES_H) + ZIW'(cur_col);
    acc_sel = acc[cur_col];
    peak    = (first_z || (data_gray > acc_sel)) ? data_gray : acc_sel;
  end

  // Counter advance: pixel within zone, zone column, line within band, band.
  always_comb begin
    px_nx  = eol_px ? '0 : cur_px + PXW'(1);
    col_nx = cur_col;
    ln_nx  = cur_ln;
    row_nx = cur_row;
    if (eol_px) begin
      col_nx = (cur_col == CL_LAST) ? '0 : cur_col + CLW'(1);
    end
    if (eol) begin
      ln_nx = (cur_ln == LN_LAST) ? '0 : cur_ln + LNW'(1);
      if (cur_ln == LN_LAST) begin
        row_nx = (cur_row == RW_LAST) ? '0 : cur_row + RWW'(1);
      end
    end
  end

  // Coordinate counters update only on in-window pixels, so blanking is harmless.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      px_cnt  <= '0;
      col_cnt <= '0;
      ln_cnt  <= '0;
      row_cnt <= '0;
    end else if (in_win) begin
      px_cnt  <= px_nx;
      col_cnt <= col_nx;
      ln_cnt  <= ln_nx;
      row_cnt <= row_nx;
    end
  end

  // Per-column running peak; reloaded on the first pixel of each zone.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ZONES_H; i++) acc[i] <= '0;
    end else if (in_win) begin
      acc[cur_col] <= peak;
    end
  end

  // Commit the finished zone peak into the shadow buffer.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_pk <= '0;
    end else if (in_win && last_z) begin
      shadow_pk[zidx*DW +: DW] <= peak;
    end
  end

  // Flag the commit of the final zone; publish happens the following cycle.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      pub_pend <= 1'b0;
    end else begin
      pub_pend <= in_win && last_z && (cur_row == RW_LAST) && (cur_col == CL_LAST);
    end
  end

`ifdef ZONE_AVG_EN
  localparam int ZA = ZONE_W * ZONE_H;
  localparam int SW = DW + ((ZA > 1) ? $clog2(ZA) : 1);

  logic [SW-1:0]    sum [ZONES_H];
  logic [SW-1:0]    sum_nx;
  logic [DW-1:0]    mean;
  logic [NZ*DW-1:0] shadow_av;

  // Running zone sum and its truncated mean at the commit pixel.
  always_comb begin
    sum_nx = first_z ? SW'(data_gray) : sum[cur_col] + SW'(data_gray);
    mean   = DW'(sum_nx / SW'(ZA));
  end

  // Per-column sum accumulator; reloaded on the first pixel of each zone.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ZONES_H; i++) sum[i] <= '0;
    end else if (in_win) begin
      sum[cur_col] <= sum_nx;
    end
  end

  // Commit the finished zone mean into its shadow buffer.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_av <= '0;
    end else if (in_win && last_z) begin
      shadow_av[zidx*DW +: DW] <= mean;
    end
  end

  // mode_avg is only looked at in the publish cycle.
  always_comb begin
    pub_val = mode_avg ? shadow_av : shadow_pk;
  end
`else
  logic unused_mode_avg;
  assign unused_mode_avg = mode_avg;

  // Peaks are the only statistic in this build.
  always_comb begin
    pub_val = shadow_pk;
  end
`endif

  // Atomic publish of the whole grid plus frame pulse and counter.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      zone_flat  <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= pub_pend;
      if (pub_pend) begin
        zone_flat <= pub_val;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_zone_stat_grid.sv
// Bench for zone_stat_grid on a 4x2 grid of 4x3 zones, window at (1,1),
// 20x10 raster with blanking gaps between lines. Expected grids come from a
// coordinate-based image model and are queued before each frame is driven.
module tb_zone_stat_grid;

  localparam int DW  = 8;
  localparam int ZH  = 4;
  localparam int ZV  = 2;
  localparam int ZW  = 4;
  localparam int ZHT = 3;
  localparam int XO  = 1;
  localparam int YO  = 1;
  localparam int FWD = 20;
  localparam int FHT = 10;
  localparam int NZ  = ZH * ZV;
  localparam int FW  = NZ * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_de = 1'b0;
  logic [10:0]   pix_x = '0;
  logic [10:0]   pix_y = '0;
  logic [DW-1:0] data_gray = '0;
  logic          mode_avg = 1'b0;
  logic [FW-1:0] zone_flat;
  logic          frame_done;
  logic [7:0]    frame_cnt;

  zone_stat_grid #(
    .DW(DW), .ZONES_H(ZH), .ZONES_V(ZV), .ZONE_W(ZW), .ZONE_H(ZHT),
    .X_OFF(XO), .Y_OFF(YO)
  ) dut (
    .i_pix_clk (clk),
    .rst_n     (rst_n),
    .data_de   (data_de),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .data_gray (data_gray),
    .mode_avg  (mode_avg),
    .zone_flat (zone_flat),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            last_win_cyc = 0;
  logic [7:0]    img [FHT][FWD];
  logic [FW-1:0] exp_q [$];
  logic [7:0]    cnt_q [$];
  logic [7:0]    exp_cnt = '0;
  logic [FW-1:0] last_pub = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every publish pops one expected grid and counter value.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_publish: got frame_done with nothing expected (zone_flat=%h)", zone_flat);
      end else begin
        logic [FW-1:0] e;
        logic [7:0]    ec;
        e  = exp_q.pop_front();
        ec = cnt_q.pop_front();
        n_cmp++;
        if (zone_flat !== e) begin
          n_bad++;
          $display("FAIL zone_flat: got %h expected %h", zone_flat, e);
        end
        n_cmp++;
        if (frame_cnt !== ec) begin
          n_bad++;
          $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt, ec);
        end
        // Pixel sampled at edge P, frame_done registered at edge P+1.
        n_cmp++;
        if (cyc - last_win_cyc != 2) begin
          n_bad++;
          $display("FAIL publish_latency: got %0d expected 2", cyc - last_win_cyc);
        end
      end
      last_pub = zone_flat;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill(input logic [7:0] v);
    for (int y = 0; y < FHT; y++)
      for (int x = 0; x < FWD; x++) img[y][x] = v;
  endtask

  task automatic fill_random();
    for (int y = 0; y < FHT; y++)
      for (int x = 0; x < FWD; x++) img[y][x] = 8'($urandom_range(0, 255));
  endtask

  task automatic push_expect();
    logic [FW-1:0] e;
    e = '0;
    for (int z = 0; z < NZ; z++) begin
      int r, c, mx, sm;
      r = z / ZH; c = z % ZH; mx = 0; sm = 0;
      for (int ly = 0; ly < ZHT; ly++)
        for (int lx = 0; lx < ZW; lx++) begin
          int v;
          v = int'(img[YO + r*ZHT + ly][XO + c*ZW + lx]);
          if (v > mx) mx = v;
          sm += v;
        end
`ifdef ZONE_AVG_EN
      if (mode_avg) e[z*DW +: DW] = 8'(sm / (ZW*ZHT));
      else          e[z*DW +: DW] = 8'(mx);
`else
      e[z*DW +: DW] = 8'(mx);
`endif
    end
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back(e);
    cnt_q.push_back(exp_cnt);
  endtask

  task automatic drive_lines(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < FWD; x++) begin
        @(negedge clk);
        data_de   = 1'b1;
        pix_x     = 11'(x);
        pix_y     = 11'(y);
        data_gray = img[y][x];
        if (x == XO + ZH*ZW - 1 && y == YO + ZV*ZHT - 1) last_win_cyc = cyc;
      end
      repeat (2) begin
        @(negedge clk);
        data_de   = 1'b0;
        data_gray = 8'hFF;
      end
    end
  endtask

  task automatic run_frame();
    push_expect();
    drive_lines(0, FHT - 1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_publish: %0d frames outstanding, expected 0", exp_q.size());
    end
    exp_q.delete();
    cnt_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (zone_flat !== '0) begin n_bad++; $display("FAIL reset_zone_flat: got %h expected 0", zone_flat); end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_cmp++;
    if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_flat();
    fill(8'h40);
    run_frame();
    n_cmp++;
    if (last_pub !== {NZ{8'h40}}) begin n_bad++; $display("FAIL flat_grid: got %h expected all 40", last_pub); end
    n_cmp++;
    if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL flat_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_single_peak();
    fill(8'h10);
    img[5][6] = 8'hFF;
    run_frame();
    n_cmp++;
    if (last_pub[5*DW +: DW] !== 8'hFF) begin n_bad++; $display("FAIL peak_zone5: got %h expected ff", last_pub[5*DW +: DW]); end
    n_cmp++;
    if (last_pub[4*DW +: DW] !== 8'h10) begin n_bad++; $display("FAIL peak_zone4: got %h expected 10", last_pub[4*DW +: DW]); end
  endtask

  task automatic test_no_carry();
    fill(8'h80);
    run_frame();
    fill(8'h20);
    run_frame();
    n_cmp++;
    if (last_pub !== {NZ{8'h20}}) begin n_bad++; $display("FAIL no_carry: got %h expected all 20", last_pub); end
  endtask

  task automatic test_out_of_window();
    fill(8'hFF);
    for (int y = YO; y < YO + ZV*ZHT; y++)
      for (int x = XO; x < XO + ZH*ZW; x++) img[y][x] = 8'h30;
    run_frame();
    n_cmp++;
    if (last_pub !== {NZ{8'h30}}) begin n_bad++; $display("FAIL out_of_window: got %h expected all 30", last_pub); end
  endtask

  task automatic test_partial_frame();
    logic [FW-1:0] held;
    held = last_pub;
    fill(8'h55);
    drive_lines(0, 4);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (zone_flat !== held) begin n_bad++; $display("FAIL partial_hold: got %h expected %h", zone_flat, held); end
    fill(8'h66);
    run_frame();
    n_cmp++;
    if (last_pub !== {NZ{8'h66}}) begin n_bad++; $display("FAIL after_partial: got %h expected all 66", last_pub); end
  endtask

  task automatic test_reset_mid_frame();
    fill(8'h11);
    run_frame();
    fill(8'h99);
    drive_lines(0, 3);
    for (int x = 0; x < 8; x++) begin
      @(negedge clk);
      data_de = 1'b1; pix_x = 11'(x); pix_y = 11'd4; data_gray = img[4][x];
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (zone_flat !== '0) begin n_bad++; $display("FAIL midreset_zone_flat: got %h expected 0", zone_flat); end
    n_cmp++;
    if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL midreset_cnt: got %0d expected 0", frame_cnt); end
    @(negedge clk);
    data_de = 1'b0;
    rst_n = 1'b1;
    exp_cnt = '0;
    drive_lines(5, FHT - 1);
    fill(8'h77);
    run_frame();
    n_cmp++;
    if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL midreset_next_cnt: got %0d expected 1", frame_cnt); end
    n_cmp++;
    if (last_pub !== {NZ{8'h77}}) begin n_bad++; $display("FAIL midreset_next_grid: got %h expected all 77", last_pub); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame();
    end
  endtask

`ifdef ZONE_AVG_EN
  task automatic test_avg();
    fill(8'h20);
    for (int y = 1; y <= 3; y++)
      for (int x = 1; x <= 4; x++) img[y][x] = 8'h64;
    for (int x = 1; x <= 4; x++) img[1][x] = 8'h00;
    img[2][1] = 8'h00;
    img[2][2] = 8'h00;
    mode_avg = 1'b1;
    run_frame();
    n_cmp++;
    if (last_pub[0 +: DW] !== 8'h32) begin n_bad++; $display("FAIL avg_zone0: got %h expected 32", last_pub[0 +: DW]); end
    n_cmp++;
    if (last_pub[1*DW +: DW] !== 8'h20) begin n_bad++; $display("FAIL avg_zone1: got %h expected 20", last_pub[1*DW +: DW]); end
    mode_avg = 1'b0;
    run_frame();
    n_cmp++;
    if (last_pub[0 +: DW] !== 8'h64) begin n_bad++; $display("FAIL avg_off_zone0: got %h expected 64", last_pub[0 +: DW]); end
  endtask
`else
  task automatic test_mode_ignored();
    fill(8'h20);
    img[2][3] = 8'hC8;
    mode_avg = 1'b1;
    run_frame();
    n_cmp++;
    if (last_pub[0 +: DW] !== 8'hC8) begin n_bad++; $display("FAIL mode_ignored: got %h expected c8", last_pub[0 +: DW]); end
    mode_avg = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_flat();
    test_single_peak();
    test_no_carry();
    test_out_of_window();
    test_partial_frame();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef ZONE_AVG_EN
    test_avg();
`else
    test_mode_ignored();
`endif
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
